// File: rtl/local_inject_arbiter.sv
// Round-robin, packet-granular arbiter that shares one router local input port
// among NREQ flit sources; a grant holds until the packet's last flit is delivered.
module local_inject_arbiter #(
  parameter int TAM_FLIT = 16,
  parameter int NREQ     = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NREQ-1:0]            en_mask,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ*TAM_FLIT-1:0]   req_flit,
  output logic [NREQ-1:0]            req_ready,
  output logic                       tx,
  output logic [TAM_FLIT-1:0]        data_out,
  input  logic                       credit_i,
  output logic                       busy,
  output logic [$clog2(NREQ)-1:0]    grant_id,
  output logic [15:0]                pkt_count
);

  localparam int GW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, HDR, SIZE, PAY} state_t;

  state_t              state_q, state_d;
  logic [GW-1:0]       grant_q, grant_d;
  logic [GW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [TAM_FLIT-1:0] remain_q, remain_d;
  logic [15:0]         pkt_count_q, pkt_count_d;

  logic [NREQ-1:0]     cand;
  logic                found;
  logic [GW-1:0]       winner;
  logic [GW:0]         sum;
  logic [TAM_FLIT-1:0] cur_flit;
  logic                xfer;
  logic                pkt_end;

  assign cand     = req_valid & en_mask;
  assign cur_flit = req_flit[grant_q*TAM_FLIT +: TAM_FLIT];

  assign busy      = (state_q != IDLE);
  assign tx        = busy & req_valid[grant_q];
  assign data_out  = busy ? cur_flit : '0;
  assign xfer      = tx & credit_i;
  assign grant_id  = grant_q;
  assign pkt_count = pkt_count_q;

  always_comb begin
    req_ready          = '0;
    req_ready[grant_q] = xfer;
  end

  // First candidate at or above rr_ptr, wrapping modulo NREQ.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    sum    = '0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      sum = {1'b0, rr_ptr_q} + (GW+1)'(off);
      if (sum >= (GW+1)'(NREQ)) sum = sum - (GW+1)'(NREQ);
      if (!found && cand[sum[GW-1:0]]) begin
        found  = 1'b1;
        winner = sum[GW-1:0];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    remain_d    = remain_q;
    pkt_count_d = pkt_count_q;
    pkt_end     = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = winner;
          state_d = HDR;
        end
      end
      HDR: begin
        if (xfer) state_d = SIZE;
      end
      SIZE: begin
        if (xfer) begin
          remain_d = cur_flit;
          if (cur_flit == '0) pkt_end = 1'b1;
          else                state_d = PAY;
        end
      end
      PAY: begin
        if (xfer) begin
          remain_d = remain_q - TAM_FLIT'(1);
          if (remain_q == TAM_FLIT'(1)) pkt_end = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (pkt_end) begin
      state_d     = IDLE;
      rr_ptr_d    = (grant_q == GW'(NREQ-1)) ? '0 : grant_q + GW'(1);
      pkt_count_d = pkt_count_q + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      remain_q    <= '0;
      pkt_count_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      remain_q    <= remain_d;
      pkt_count_q <= pkt_count_d;
    end
  end

endmodule

// File: tb/tb_local_inject_arbiter.sv
// Directed self-checking bench for local_inject_arbiter: queue-backed sources
// feed the DUT while scenario tasks compare the delivered flit stream.
module tb_local_inject_arbiter;

  localparam int TF = 16;
  localparam int NR = 4;

  logic              clock;
  logic              reset;
  logic [NR-1:0]     en_mask;
  logic [NR-1:0]     req_valid;
  logic [NR*TF-1:0]  req_flit;
  logic [NR-1:0]     req_ready;
  logic              tx;
  logic [TF-1:0]     data_out;
  logic              credit_i;
  logic              busy;
  logic [1:0]        grant_id;
  logic [15:0]       pkt_count;

  int checks = 0;
  int errors = 0;

  local_inject_arbiter #(.TAM_FLIT(TF), .NREQ(NR)) dut (
    .clock(clock), .reset(reset), .en_mask(en_mask), .req_valid(req_valid),
    .req_flit(req_flit), .req_ready(req_ready), .tx(tx), .data_out(data_out),
    .credit_i(credit_i), .busy(busy), .grant_id(grant_id), .pkt_count(pkt_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  logic [15:0] q [NR][$];
  bit          stall [NR];
  bit          cred_mode;
  int          cyc;
  int          txcnt, busycnt, popcnt, bad_ready, first_tx, last_tx;
  int          xg [$];
  logic [15:0] xd [$];

  // Source model: present queue heads on the falling edge, pop on req_ready.
  initial begin
    req_valid = '0;
    req_flit  = '0;
    credit_i  = 1'b1;
    cyc       = 0;
    forever begin
      @(negedge clock);
      cyc++;
      for (int i = 0; i < NR; i++) begin
        req_valid[i]          = (q[i].size() > 0) && !stall[i];
        req_flit[i*TF +: TF]  = (q[i].size() > 0) ? q[i][0] : 16'h0000;
      end
      credit_i = cred_mode ? (cyc % 3 == 0) : 1'b1;
      #1;
      if (tx) begin
        txcnt++;
        if (first_tx < 0) first_tx = cyc;
        last_tx = cyc;
      end
      if (busy) busycnt++;
      if (tx && credit_i) begin
        xg.push_back(int'(grant_id));
        xd.push_back(data_out);
      end
      for (int i = 0; i < NR; i++) begin
        if (req_ready[i]) begin
          popcnt++;
          if (!credit_i || q[i].size() == 0) bad_ready++;
          else void'(q[i].pop_front());
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic clear_logs();
    xg.delete();
    xd.delete();
    txcnt = 0; busycnt = 0; popcnt = 0; bad_ready = 0;
    first_tx = -1; last_tx = -1;
  endtask

  task automatic test_reset();
    step(2);
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL rst_tx got %b want 0", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL rst_grant got %0d want 0", grant_id); end
    checks++; if (pkt_count !== 16'd0) begin errors++; $display("FAIL rst_pkt got %0d want 0", pkt_count); end
    checks++; if (data_out !== 16'h0) begin errors++; $display("FAIL rst_data got %h want 0", data_out); end
    checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL rst_ready got %b want 0", req_ready); end
    reset = 1'b1;
    step(1);
  endtask

  task automatic test_single();
    logic [15:0] ed [5] = '{16'h0011, 16'h0003, 16'hA0A0, 16'hB0B0, 16'hC0C0};
    clear_logs();
    for (int j = 0; j < 5; j++) q[0].push_back(ed[j]);
    step(12);
    checks++; if (xd.size() != 5) begin errors++; $display("FAIL single_len got %0d want 5", xd.size()); end
    for (int j = 0; j < 5 && j < xd.size(); j++) begin
      checks++;
      if (xd[j] !== ed[j] || xg[j] != 0) begin
        errors++; $display("FAIL single_flit%0d got %0d:%h want 0:%h", j, xg[j], xd[j], ed[j]);
      end
    end
    checks++; if (txcnt != 5 || last_tx - first_tx != 4) begin
      errors++; $display("FAIL single_txrun got cnt=%0d span=%0d want 5/4", txcnt, last_tx - first_tx); end
    checks++; if (busycnt != 5) begin errors++; $display("FAIL single_busy got %0d want 5", busycnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end got %b want 0", busy); end
    checks++; if (pkt_count !== 16'd1) begin errors++; $display("FAIL single_pkt got %0d want 1", pkt_count); end
  endtask

  // rr_ptr is 1 here, so requester 1 must beat requester 3; the pointer then wraps to 0.
  task automatic test_zero_size();
    int          eg [4] = '{1, 1, 3, 3};
    logic [15:0] ed [4] = '{16'h0101, 16'h0000, 16'h0303, 16'h0000};
    clear_logs();
    q[1].push_back(16'h0101); q[1].push_back(16'h0000);
    q[3].push_back(16'h0303); q[3].push_back(16'h0000);
    step(10);
    checks++; if (xd.size() != 4) begin errors++; $display("FAIL zero_len got %0d want 4", xd.size()); end
    for (int j = 0; j < 4 && j < xd.size(); j++) begin
      checks++;
      if (xd[j] !== ed[j] || xg[j] != eg[j]) begin
        errors++; $display("FAIL zero_flit%0d got %0d:%h want %0d:%h", j, xg[j], xd[j], eg[j], ed[j]);
      end
    end
    checks++; if (pkt_count !== 16'd3) begin errors++; $display("FAIL zero_pkt got %0d want 3", pkt_count); end
  endtask

  task automatic test_round_robin();
    int n;
    clear_logs();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < NR; i++) begin
        q[i].push_back(16'(16'h1000 + i*16 + k));
        q[i].push_back(16'h0001);
        q[i].push_back(16'(16'hA000 + i*16 + k));
      end
    step(40);
    checks++; if (xd.size() != 24) begin errors++; $display("FAIL rr_len got %0d want 24", xd.size()); end
    n = 0;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < NR; i++) begin
        if (n + 2 < xd.size()) begin
          checks++;
          if (xg[n] != i || xg[n+1] != i || xg[n+2] != i ||
              xd[n] !== 16'(16'h1000 + i*16 + k) || xd[n+1] !== 16'h0001 ||
              xd[n+2] !== 16'(16'hA000 + i*16 + k)) begin
            errors++;
            $display("FAIL rr_pkt%0d got g=%0d,%0d,%0d d=%h,%h,%h want g=%0d d=%h,0001,%h", n/3,
                     xg[n], xg[n+1], xg[n+2], xd[n], xd[n+1], xd[n+2], i,
                     16'(16'h1000 + i*16 + k), 16'(16'hA000 + i*16 + k));
          end
        end
        n += 3;
      end
    checks++; if (pkt_count !== 16'd11) begin errors++; $display("FAIL rr_pkt got %0d want 11", pkt_count); end
  endtask

  task automatic test_backpressure();
    logic [15:0] ed [6] = '{16'h0022, 16'h0004, 16'hD001, 16'hD002, 16'hD003, 16'hD004};
    clear_logs();
    cred_mode = 1'b1;
    for (int j = 0; j < 6; j++) q[2].push_back(ed[j]);
    step(30);
    cred_mode = 1'b0;
    checks++; if (xd.size() != 6) begin errors++; $display("FAIL bp_len got %0d want 6", xd.size()); end
    for (int j = 0; j < 6 && j < xd.size(); j++) begin
      checks++;
      if (xd[j] !== ed[j] || xg[j] != 2) begin
        errors++; $display("FAIL bp_flit%0d got %0d:%h want 2:%h", j, xg[j], xd[j], ed[j]);
      end
    end
    checks++; if (bad_ready != 0) begin errors++; $display("FAIL bp_ready_nocredit got %0d want 0", bad_ready); end
    checks++; if (popcnt != 6) begin errors++; $display("FAIL bp_pops got %0d want 6", popcnt); end
    checks++; if (pkt_count !== 16'd12) begin errors++; $display("FAIL bp_pkt got %0d want 12", pkt_count); end
  endtask

  task automatic test_stall();
    int          eg [7] = '{0, 0, 0, 0, 0, 2, 2};
    logic [15:0] ed [7] = '{16'h0033, 16'h0003, 16'hE001, 16'hE002, 16'hE003, 16'h0044, 16'h0000};
    int          waited;
    clear_logs();
    for (int j = 0; j < 5; j++) q[0].push_back(ed[j]);
    waited = 0;
    while (xd.size() < 3 && waited < 20) begin
      step(1);
      waited++;
    end
    checks++; if (xd.size() < 3) begin errors++; $display("FAIL stall_start got %0d flits want 3", xd.size()); end
    stall[0] = 1'b1;
    q[2].push_back(16'h0044); q[2].push_back(16'h0000);
    for (int c = 0; c < 3; c++) begin
      @(negedge clock); #2;
      checks++;
      if (tx !== 1'b0 || busy !== 1'b1 || grant_id !== 2'd0 || req_ready !== 4'b0) begin
        errors++; $display("FAIL stall_hold%0d got tx=%b busy=%b g=%0d rdy=%b want 0/1/0/0",
                           c, tx, busy, grant_id, req_ready);
      end
    end
    stall[0] = 1'b0;
    step(15);
    checks++; if (xd.size() != 7) begin errors++; $display("FAIL stall_len got %0d want 7", xd.size()); end
    for (int j = 0; j < 7 && j < xd.size(); j++) begin
      checks++;
      if (xd[j] !== ed[j] || xg[j] != eg[j]) begin
        errors++; $display("FAIL stall_flit%0d got %0d:%h want %0d:%h", j, xg[j], xd[j], eg[j], ed[j]);
      end
    end
    checks++; if (pkt_count !== 16'd14) begin errors++; $display("FAIL stall_pkt got %0d want 14", pkt_count); end
  endtask

  task automatic test_mask();
    int          eg [8] = '{3, 3, 1, 1, 3, 3, 1, 1};
    logic [15:0] ed [8] = '{16'h5003, 16'h0, 16'h5001, 16'h0, 16'h5003, 16'h0, 16'h5001, 16'h0};
    clear_logs();
    en_mask = 4'b1010;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < NR; i++) begin
        q[i].push_back(16'(16'h5000 + i));
        q[i].push_back(16'h0000);
      end
    step(20);
    checks++; if (xd.size() != 8) begin errors++; $display("FAIL mask_len got %0d want 8", xd.size()); end
    for (int j = 0; j < 8 && j < xd.size(); j++) begin
      checks++;
      if (xd[j] !== ed[j] || xg[j] != eg[j]) begin
        errors++; $display("FAIL mask_flit%0d got %0d:%h want %0d:%h", j, xg[j], xd[j], eg[j], ed[j]);
      end
    end
    checks++; if (q[0].size() != 4 || q[2].size() != 4) begin
      errors++; $display("FAIL mask_pending got %0d,%0d want 4,4", q[0].size(), q[2].size()); end
    checks++; if (pkt_count !== 16'd18) begin errors++; $display("FAIL mask_pkt got %0d want 18", pkt_count); end
    q[0].delete(); q[2].delete();
    en_mask = '1;
    step(1);
  endtask

  task automatic test_reset_mid();
    int          eg [4] = '{0, 0, 1, 1};
    logic [15:0] ed [4] = '{16'h0700, 16'h0000, 16'h0701, 16'h0000};
    int          waited;
    clear_logs();
    q[2].push_back(16'h0066); q[2].push_back(16'h0003);
    q[2].push_back(16'hF001); q[2].push_back(16'hF002); q[2].push_back(16'hF003);
    waited = 0;
    while (xd.size() < 3 && waited < 20) begin
      step(1);
      waited++;
    end
    checks++; if (xd.size() < 3) begin errors++; $display("FAIL rstmid_start got %0d flits want 3", xd.size()); end
    reset = 1'b0;
    #1;
    checks++;
    if (tx !== 1'b0 || busy !== 1'b0 || pkt_count !== 16'd0 || grant_id !== 2'd0 || req_ready !== 4'b0) begin
      errors++; $display("FAIL rstmid_async got tx=%b busy=%b pkt=%0d g=%0d rdy=%b want all 0",
                         tx, busy, pkt_count, grant_id, req_ready);
    end
    for (int i = 0; i < NR; i++) q[i].delete();
    step(2);
    reset = 1'b1;
    clear_logs();
    q[1].push_back(16'h0701); q[1].push_back(16'h0000);
    q[0].push_back(16'h0700); q[0].push_back(16'h0000);
    step(10);
    checks++; if (xd.size() != 4) begin errors++; $display("FAIL rstmid_len got %0d want 4", xd.size()); end
    for (int j = 0; j < 4 && j < xd.size(); j++) begin
      checks++;
      if (xd[j] !== ed[j] || xg[j] != eg[j]) begin
        errors++; $display("FAIL rstmid_flit%0d got %0d:%h want %0d:%h", j, xg[j], xd[j], eg[j], ed[j]);
      end
    end
    checks++; if (pkt_count !== 16'd2) begin errors++; $display("FAIL rstmid_pkt got %0d want 2", pkt_count); end
  endtask

  initial begin
    reset     = 1'b0;
    en_mask   = '1;
    cred_mode = 1'b0;
    for (int i = 0; i < NR; i++) stall[i] = 1'b0;
    clear_logs();
    test_reset();
    test_single();
    test_zero_size();
    test_round_robin();
    test_backpressure();
    test_stall();
    test_mask();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/local_inject_arbiter.md
# local_inject_arbiter

- Shares one router's local input port among `NREQ` packet sources.
- Arbitration is round-robin at packet granularity, following wormhole rules: once a source is granted, the port stays with it until that packet's last flit has been delivered.
- Sits between the traffic sources (cores / DMA) of one mesh node and that node's router local port (`rxLocal`/`data_inLocal_flit`/`credit_oLocal` lanes at NOC level).
- Packet format is fixed: flit 0 = target address {X,Y}, flit 1 = payload size N, then N payload flits.

## Interface

Parameters:
- `TAM_FLIT`, 16: flit width in bits.
- `NREQ`, 4: number of requesters, 2..8.

Ports:
- `clock`  in  1  : single clock; all state updates on the rising edge.
- `reset`  in  1  : asynchronous, active-low reset.
- `en_mask`  in  NREQ  : per-requester enable; a cleared bit excludes that requester from new grants and does not abort a packet already in flight.
- `req_valid`  in  NREQ  : requester i presents a valid flit.
- `req_flit`  in  NREQ*TAM_FLIT  : flit of requester i at `[i*TAM_FLIT +: TAM_FLIT]`.
- `req_ready`  out  NREQ  : flit of requester i consumed this cycle (pop).
- `tx`  out  1  : drives router local `rx`.
- `data_out`  out  TAM_FLIT  : drives router local data_in.
- `credit_i`  in  1  : router local `credit_o`; high means the router can accept a flit.
- `busy`  out  1  : packet in flight.
- `grant_id`  out  clog2(NREQ)  : current or last granted requester.
- `pkt_count`  out  16  : packets completed, wraps at 0xFFFF to 0.

## Operation

- Transfer rule: a flit moves when `tx && credit_i` is high; this is the only handshake.
- In any state other than IDLE, `tx` = `req_valid[grant_id]` and `data_out` = the granted requester's flit; both are combinational.
- `req_ready[i]` = (i == `grant_id`) && `tx` && `credit_i` && state ≠ IDLE. All other requesters see 0.
- State machine:
  - IDLE: `tx` = 0 and `data_out` = 0. Candidates = `req_valid & en_mask`. If any candidate exists, grant the first one searching upward from `rr_ptr` with wraparound, then go to HDR.
  - HDR: on a transfer, go to SIZE.
  - SIZE: on a transfer, load `remain` = the flit value. If the value is 0, the packet ends (see below). Otherwise go to PAY.
  - PAY: on each transfer, `remain` decrements. A transfer with `remain` == 1 ends the packet.
- Packet end: return to IDLE; `rr_ptr` = (`grant_id` + 1) mod NREQ; `pkt_count` increments.
- Stalls: if the granted requester drops `req_valid`, or `credit_i` is low, the state holds indefinitely. There is no timeout and no re-arbitration mid-packet.
- `remain` is TAM_FLIT bits wide, so the maximum payload is 2^TAM_FLIT − 1 flits.
- `busy` = state ≠ IDLE.
- Changing `en_mask` mid-packet affects only the next arbitration.

## Timing

- Reset values: state = IDLE, `rr_ptr` = 0, `grant_id` = 0, `remain` = 0, `pkt_count` = 0, `busy` = 0, `tx` = 0, `data_out` = 0, `req_ready` = 0.
- Outputs go low asynchronously on `reset` assertion, including mid-packet. The partial packet is abandoned and the requester must restart it.
- Arbitration latency: a request in IDLE at edge k → grant registered at edge k → header can transfer in cycle k+1.
- Throughput: 1 flit/cycle while the grant holds and `credit_i` and `req_valid` stay high.
- A packet of N payload flits occupies N+2 transfer cycles plus 1 IDLE cycle, so the minimum gap between packets is 1 cycle.
- Simultaneous requests: the lowest index at or above `rr_ptr` wins. `rr_ptr` only moves at packet end.
- Requests that appear after the grant wait for the current packet to finish.

## Test plan

- Single packet: requester 0 sends {0x0011, 0x0003, A, B, C} with `credit_i` = 1 → `tx` high for exactly 5 consecutive cycles, `data_out` sequence matches, `pkt_count` = 1, `rr_ptr` = 1, `busy` falls after the last flit.
- Round robin: all 4 requesters send back-to-back size-1 packets, held valid → grants 0,1,2,3,0,…. No flit interleaving occurs between packets.
- Backpressure: `credit_i` toggles 1,0,0,1,… during a size-4 packet → each flit is transferred exactly once, `req_ready` pulses only on cycles with `credit_i` = 1, and order is preserved.
- Zero-size and source stall:
  - A size-0 packet ends after 2 flits.
  - The granted source drops `req_valid` for 3 cycles mid-payload → `tx` = 0 and the state holds; requester 2 valid during the stall is not granted until the packet completes.
- Mask and reset:
  - `en_mask` = 0b1010 with all requesters valid → only 1 and 3 are ever granted.
  - `reset` asserted mid-payload → `tx`, `busy`, `pkt_count` and `grant_id` are 0 immediately; after release, arbitration restarts from requester 0.
